// File: rtl/io_channels.sv
// io_channels: NCHAN loader-fed input FIFOs popped by a CPU request/ack port,
// and NCHAN CPU-written output FIFOs emptied through a valid/ready drain port.
// Optional feature macro: IO_CHANNELS_OVERWRITE_EN
//   defined   -> a write to a full output FIFO overwrites the oldest entry
//   undefined -> the write is dropped and the channel's sticky overflow flag is set
module io_channels #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NCHAN = 2,
    localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int unsigned SW = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    // loader side of the input FIFOs
    input  logic             i_ld_valid,
    input  logic [CW-1:0]    i_ld_chan,
    input  logic [WIDTH-1:0] i_ld_data,
    output logic             o_ld_ready,
    // CPU pop side of the input FIFOs
    input  logic             i_in_req,
    input  logic [CW-1:0]    i_in_chan,
    output logic [SW-1:0]    o_in_size,
    output logic [WIDTH-1:0] o_in_data,
    output logic             o_in_ack,
    output logic             o_in_empty,
    // CPU write side of the output FIFOs
    input  logic             i_out_valid,
    input  logic [CW-1:0]    i_out_chan,
    input  logic [WIDTH-1:0] i_out_data,
    // drain side of the output FIFOs
    input  logic [CW-1:0]    i_dr_chan,
    output logic             o_dr_valid,
    output logic [WIDTH-1:0] o_dr_data,
    input  logic             i_dr_ready,
    output logic [NCHAN-1:0] o_out_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [SW-1:0] FULL = SW'(DEPTH);

    // per-channel views exported by the FIFO generate blocks
    logic [SW-1:0]    w_in_cnt   [NCHAN];
    logic [WIDTH-1:0] w_in_head  [NCHAN];
    logic [SW-1:0]    w_out_cnt  [NCHAN];
    logic [WIDTH-1:0] w_out_head [NCHAN];

    // per-channel strobes
    logic [NCHAN-1:0] w_ld_hit;
    logic [NCHAN-1:0] w_pop;
    logic [NCHAN-1:0] w_wr;
    logic [NCHAN-1:0] w_rd;
    logic [NCHAN-1:0] w_ovf;

    // channel-selected views
    logic             w_ld_ok;
    logic [SW-1:0]    w_ld_cnt;
    logic             w_in_ok;
    logic [SW-1:0]    w_in_sel_cnt;
    logic [WIDTH-1:0] w_in_sel_head;
    logic             w_dr_ok;
    logic [SW-1:0]    w_dr_cnt;
    logic [WIDTH-1:0] w_dr_head;
    logic             w_pop_any;

    logic [WIDTH-1:0] r_in_data;
    logic             r_in_ack;
    logic             r_in_empty;

    // Select the addressed channel for each port; out-of-range channels read as absent/empty.
    always_comb begin
        w_ld_ok       = 1'b0;
        w_ld_cnt      = '0;
        w_in_ok       = 1'b0;
        w_in_sel_cnt  = '0;
        w_in_sel_head = '0;
        w_dr_ok       = 1'b0;
        w_dr_cnt      = '0;
        w_dr_head     = '0;
        for (int c = 0; c < int'(NCHAN); c++) begin
            if (i_ld_chan == CW'(c)) begin
                w_ld_ok  = 1'b1;
                w_ld_cnt = w_in_cnt[c];
            end
            if (i_in_chan == CW'(c)) begin
                w_in_ok       = 1'b1;
                w_in_sel_cnt  = w_in_cnt[c];
                w_in_sel_head = w_in_head[c];
            end
            if (i_dr_chan == CW'(c)) begin
                w_dr_ok   = 1'b1;
                w_dr_cnt  = w_out_cnt[c];
                w_dr_head = w_out_head[c];
            end
        end
    end

    // Combinational handshakes; ld_ready looks only at the pre-edge count.
    assign o_ld_ready = w_ld_ok && (w_ld_cnt < FULL);
    assign o_in_size  = w_in_sel_cnt;
    assign w_pop_any  = i_in_req && w_in_ok && (w_in_sel_cnt != '0);
    assign o_dr_valid = w_dr_ok && (w_dr_cnt != '0);
    assign o_dr_data  = w_dr_head;

    genvar c;
    generate
        for (c = 0; c < int'(NCHAN); c++) begin : g_in_ch
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [AW-1:0]    r_wptr;
            logic [AW-1:0]    r_rptr;
            logic [SW-1:0]    r_cnt;

            assign w_ld_hit[c]  = i_ld_valid && o_ld_ready && (i_ld_chan == CW'(c));
            assign w_pop[c]     = w_pop_any && (i_in_chan == CW'(c));
            assign w_in_cnt[c]  = r_cnt;
            assign w_in_head[c] = r_mem[r_rptr];

            // Input FIFO storage, not reset.
            always_ff @(posedge i_clock) begin
                if (w_ld_hit[c] && !i_reset) begin
                    r_mem[r_wptr] <= i_ld_data;
                end
            end

            // Input FIFO pointers and count; simultaneous load and pop leave the count unchanged.
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_ld_hit[c]) begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                    if (w_pop[c]) begin
                        r_rptr <= r_rptr + AW'(1);
                    end
                    case ({w_ld_hit[c], w_pop[c]})
                        2'b10:   r_cnt <= r_cnt + SW'(1);
                        2'b01:   r_cnt <= r_cnt - SW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end

        for (c = 0; c < int'(NCHAN); c++) begin : g_out_ch
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [AW-1:0]    r_wptr;
            logic [AW-1:0]    r_rptr;
            logic [SW-1:0]    r_cnt;
            logic             r_ovf;
            logic             w_full;
            logic             w_accept;
            logic             w_ovw;
            logic             w_drop;

            assign w_wr[c]       = i_out_valid && (i_out_chan == CW'(c));
            assign w_rd[c]       = i_dr_ready && o_dr_valid && (i_dr_chan == CW'(c));
            assign w_full        = (r_cnt == FULL);
            assign w_out_cnt[c]  = r_cnt;
            assign w_out_head[c] = r_mem[r_rptr];
            assign w_ovf[c]      = r_ovf;

`ifdef IO_CHANNELS_OVERWRITE_EN
            // Full without a drain: write anyway and push the oldest entry out.
            assign w_accept = w_wr[c];
            assign w_ovw    = w_wr[c] && w_full && !w_rd[c];
            assign w_drop   = 1'b0;
`else
            // Full without a drain: drop the write and flag it.
            assign w_accept = w_wr[c] && (!w_full || w_rd[c]);
            assign w_ovw    = 1'b0;
            assign w_drop   = w_wr[c] && w_full && !w_rd[c];
`endif

            // Output FIFO storage, not reset.
            always_ff @(posedge i_clock) begin
                if (w_accept && !i_reset) begin
                    r_mem[r_wptr] <= i_out_data;
                end
            end

            // Output FIFO pointers, count and sticky overflow flag.
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    if (w_accept) begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                    if (w_rd[c] || w_ovw) begin
                        r_rptr <= r_rptr + AW'(1);
                    end
                    case ({w_accept && !w_ovw, w_rd[c]})
                        2'b10:   r_cnt <= r_cnt + SW'(1);
                        2'b01:   r_cnt <= r_cnt - SW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                    if (w_drop) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign o_out_overflow = w_ovf;

    // CPU pop response: ack every request one cycle later, empty holds between acks.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_in_ack   <= 1'b0;
            r_in_empty <= 1'b0;
            r_in_data  <= '0;
        end else begin
            r_in_ack <= i_in_req;
            if (i_in_req) begin
                r_in_empty <= !w_pop_any;
            end
            if (w_pop_any) begin
                r_in_data <= w_in_sel_head;
            end
        end
    end

    assign o_in_ack   = r_in_ack;
    assign o_in_empty = r_in_empty;
    assign o_in_data  = r_in_data;

endmodule

// File: tb/tb_io_channels.sv
// Self-checking bench for io_channels (DEPTH=4, NCHAN=3 so channel 3 is out of range).
module tb_io_channels;

    localparam int unsigned W  = 12;
    localparam int unsigned D  = 4;
    localparam int unsigned N  = 3;
    localparam int unsigned CW = 2;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic [CW-1:0] ld_chan;
    logic [W-1:0]  ld_data;
    logic          ld_ready;
    logic          in_req;
    logic [CW-1:0] in_chan;
    logic [SW-1:0] in_size;
    logic [W-1:0]  in_data;
    logic          in_ack;
    logic          in_empty;
    logic          out_valid;
    logic [CW-1:0] out_chan;
    logic [W-1:0]  out_data;
    logic [CW-1:0] dr_chan;
    logic          dr_valid;
    logic [W-1:0]  dr_data;
    logic          dr_ready;
    logic [N-1:0]  ovf;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_in[$];
    logic [W-1:0] last_pop;

    always #5 clk = ~clk;

    io_channels #(.WIDTH(W), .DEPTH(D), .NCHAN(N)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_ld_valid(ld_valid), .i_ld_chan(ld_chan), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
        .i_in_req(in_req), .i_in_chan(in_chan), .o_in_size(in_size), .o_in_data(in_data),
        .o_in_ack(in_ack), .o_in_empty(in_empty),
        .i_out_valid(out_valid), .i_out_chan(out_chan), .i_out_data(out_data),
        .i_dr_chan(dr_chan), .o_dr_valid(dr_valid), .o_dr_data(dr_data), .i_dr_ready(dr_ready),
        .o_out_overflow(ovf)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ld_valid = 1'b0; ld_chan = '0; ld_data = '0;
        in_req = 1'b0; in_chan = '0;
        out_valid = 1'b0; out_chan = '0; out_data = '0;
        dr_chan = '0; dr_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        n_vec++; if (in_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got %0d want 0", in_ack); end
        n_vec++; if (in_empty !== 1'b0) begin n_err++; $display("FAIL rst_empty got %0d want 0", in_empty); end
        n_vec++; if (in_data !== 12'd0) begin n_err++; $display("FAIL rst_data got %0d want 0", in_data); end
        n_vec++; if (ovf !== 3'b000) begin n_err++; $display("FAIL rst_ovf got %b want 000", ovf); end
        n_vec++; if (in_size !== 3'd0) begin n_err++; $display("FAIL rst_size got %0d want 0", in_size); end
        n_vec++; if (dr_valid !== 1'b0) begin n_err++; $display("FAIL rst_dr_valid got %0d want 0", dr_valid); end
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL rst_ld_ready got %0d want 1", ld_ready); end
    endtask

    task automatic test_load_pop;
        int d[3] = '{33, 22, 11};
        logic [W-1:0] e;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_chan = 2'd0; ld_data = W'(d[i]);
            #1;
            n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL lp_ld_ready[%0d] got %0d want 1", i, ld_ready); end
            step();
        end
        ld_valid = 1'b0;
        in_chan = 2'd0;
        #1;
        n_vec++; if (in_size !== 3'd3) begin n_err++; $display("FAIL lp_size_loaded got %0d want 3", in_size); end
        for (int i = 0; i < 3; i++) begin
            in_req = 1'b1;
            exp_q.push_back(W'(d[i]));
            step();
            in_req = 1'b0;
            #1;
            e = exp_q.pop_front();
            n_vec++; if (in_ack !== 1'b1) begin n_err++; $display("FAIL lp_ack[%0d] got %0d want 1", i, in_ack); end
            n_vec++; if (in_empty !== 1'b0) begin n_err++; $display("FAIL lp_empty[%0d] got %0d want 0", i, in_empty); end
            n_vec++; if (in_data !== e) begin n_err++; $display("FAIL lp_data[%0d] got %0d want %0d", i, in_data, e); end
            n_vec++; if (in_size !== SW'(2 - i)) begin n_err++; $display("FAIL lp_size[%0d] got %0d want %0d", i, in_size, 2 - i); end
        end
        in_req = 1'b1;
        step();
        in_req = 1'b0;
        #1;
        n_vec++; if (in_ack !== 1'b1) begin n_err++; $display("FAIL lp_empty_ack got %0d want 1", in_ack); end
        n_vec++; if (in_empty !== 1'b1) begin n_err++; $display("FAIL lp_empty_flag got %0d want 1", in_empty); end
        n_vec++; if (in_data !== 12'd11) begin n_err++; $display("FAIL lp_empty_data got %0d want 11", in_data); end
        step();
        n_vec++; if (in_ack !== 1'b0) begin n_err++; $display("FAIL lp_ack_idle got %0d want 0", in_ack); end
        n_vec++; if (in_empty !== 1'b1) begin n_err++; $display("FAIL lp_empty_hold got %0d want 1", in_empty); end
    endtask

    task automatic test_out_drain;
        logic [W-1:0] e;
        int guard;
        for (int v = 1; v <= 3; v++) begin
            out_valid = 1'b1; out_chan = 2'd1; out_data = W'(v);
            exp_q.push_back(W'(v));
            step();
        end
        out_valid = 1'b0;
        dr_chan = 2'd0;
        #1;
        n_vec++; if (dr_valid !== 1'b0) begin n_err++; $display("FAIL od_ch0_valid got %0d want 0", dr_valid); end
        dr_chan = 2'd1; dr_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            #1;
            e = exp_q.pop_front();
            n_vec++; if (dr_valid !== 1'b1) begin n_err++; $display("FAIL od_valid got %0d want 1", dr_valid); end
            n_vec++; if (dr_data !== e) begin n_err++; $display("FAIL od_data got %0d want %0d", dr_data, e); end
            step();
            guard++;
        end
        n_vec++; if (dr_valid !== 1'b0) begin n_err++; $display("FAIL od_drained_valid got %0d want 0", dr_valid); end
        dr_ready = 1'b0;
        dr_chan = 2'd0;
        #1;
        n_vec++; if (dr_valid !== 1'b0) begin n_err++; $display("FAIL od_ch0_after got %0d want 0", dr_valid); end
    endtask

    task automatic test_overflow;
        logic [W-1:0] e;
        logic [N-1:0] ovf_exp;
        int guard;
`ifdef IO_CHANNELS_OVERWRITE_EN
        for (int v = 2; v <= 5; v++) exp_q.push_back(W'(v));
        ovf_exp = 3'b000;
`else
        for (int v = 1; v <= 4; v++) exp_q.push_back(W'(v));
        ovf_exp = 3'b001;
`endif
        for (int v = 1; v <= 5; v++) begin
            out_valid = 1'b1; out_chan = 2'd0; out_data = W'(v);
            step();
        end
        out_valid = 1'b0;
        #1;
        n_vec++; if (ovf !== ovf_exp) begin n_err++; $display("FAIL ov_flag got %b want %b", ovf, ovf_exp); end
        dr_chan = 2'd0; dr_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            #1;
            e = exp_q.pop_front();
            n_vec++; if (dr_valid !== 1'b1) begin n_err++; $display("FAIL ov_valid got %0d want 1", dr_valid); end
            n_vec++; if (dr_data !== e) begin n_err++; $display("FAIL ov_data got %0d want %0d", dr_data, e); end
            step();
            guard++;
        end
        n_vec++; if (dr_valid !== 1'b0) begin n_err++; $display("FAIL ov_drained got %0d want 0", dr_valid); end
        n_vec++; if (ovf !== ovf_exp) begin n_err++; $display("FAIL ov_sticky got %b want %b", ovf, ovf_exp); end
        dr_ready = 1'b0;
    endtask

    task automatic test_full_pop;
        logic [W-1:0] e;
        for (int v = 100; v < 104; v++) begin
            ld_valid = 1'b1; ld_chan = 2'd0; ld_data = W'(v);
            m_in.push_back(W'(v));
            step();
        end
        ld_data = 12'd104; in_req = 1'b1; in_chan = 2'd0;
        #1;
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL fp_full_ready got %0d want 0", ld_ready); end
        n_vec++; if (in_size !== 3'd4) begin n_err++; $display("FAIL fp_full_size got %0d want 4", in_size); end
        e = m_in.pop_front();
        step();
        in_req = 1'b0;
        #1;
        n_vec++; if (in_data !== e || in_ack !== 1'b1 || in_empty !== 1'b0) begin n_err++; $display("FAIL fp_pop data %0d ack %0d empty %0d want %0d 1 0", in_data, in_ack, in_empty, e); end
        n_vec++; if (in_size !== 3'd3) begin n_err++; $display("FAIL fp_size_after got %0d want 3", in_size); end
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL fp_retry_ready got %0d want 1", ld_ready); end
        m_in.push_back(12'd104);
        step();
        ld_valid = 1'b0;
        #1;
        n_vec++; if (in_size !== 3'd4) begin n_err++; $display("FAIL fp_refill_size got %0d want 4", in_size); end
        in_req = 1'b1;
        e = m_in.pop_front();
        step();
        in_req = 1'b0;
        #1;
        n_vec++; if (in_data !== e) begin n_err++; $display("FAIL fp_prepop got %0d want %0d", in_data, e); end
        for (int k = 0; k < 10; k++) begin
            ld_valid = 1'b1; ld_data = W'(200 + k); in_req = 1'b1;
            #1;
            n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL fp_pair_ready[%0d] got %0d want 1", k, ld_ready); end
            e = m_in.pop_front();
            m_in.push_back(W'(200 + k));
            step();
            ld_valid = 1'b0; in_req = 1'b0;
            #1;
            n_vec++; if (in_data !== e || in_ack !== 1'b1) begin n_err++; $display("FAIL fp_pair_data[%0d] got %0d ack %0d want %0d", k, in_data, in_ack, e); end
            n_vec++; if (in_size !== 3'd3) begin n_err++; $display("FAIL fp_pair_size[%0d] got %0d want 3", k, in_size); end
        end
        while (m_in.size() > 0) begin
            in_req = 1'b1;
            e = m_in.pop_front();
            step();
            in_req = 1'b0;
            #1;
            n_vec++; if (in_data !== e || in_empty !== 1'b0) begin n_err++; $display("FAIL fp_tail got %0d empty %0d want %0d", in_data, in_empty, e); end
            last_pop = e;
        end
        n_vec++; if (in_size !== 3'd0) begin n_err++; $display("FAIL fp_final_size got %0d want 0", in_size); end
    endtask

    task automatic test_bad_chan;
        ld_valid = 1'b1; ld_chan = 2'd3; ld_data = 12'd55;
        #1;
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL bc_ld_ready got %0d want 0", ld_ready); end
        step();
        ld_valid = 1'b0;
        in_chan = 2'd3;
        #1;
        n_vec++; if (in_size !== 3'd0) begin n_err++; $display("FAIL bc_size got %0d want 0", in_size); end
        in_req = 1'b1;
        step();
        in_req = 1'b0;
        #1;
        n_vec++; if (in_ack !== 1'b1 || in_empty !== 1'b1) begin n_err++; $display("FAIL bc_pop ack %0d empty %0d want 1 1", in_ack, in_empty); end
        n_vec++; if (in_data !== last_pop) begin n_err++; $display("FAIL bc_data got %0d want %0d", in_data, last_pop); end
        out_valid = 1'b1; out_chan = 2'd3; out_data = 12'd7;
        step();
        out_valid = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            dr_chan = CW'(ch);
            #1;
            n_vec++; if (dr_valid !== 1'b0) begin n_err++; $display("FAIL bc_dr_valid[%0d] got %0d want 0", ch, dr_valid); end
        end
    endtask

    task automatic test_reset_mid;
        ld_valid = 1'b1; ld_chan = 2'd1; ld_data = 12'd5;
        step();
        ld_valid = 1'b0;
        out_valid = 1'b1; out_chan = 2'd2; out_data = 12'd9;
        step();
        rst = 1'b1;
        ld_valid = 1'b1; ld_chan = 2'd1; ld_data = 12'd6;
        in_req = 1'b1; in_chan = 2'd1;
        out_valid = 1'b1; out_chan = 2'd2; out_data = 12'd8;
        dr_ready = 1'b1; dr_chan = 2'd2;
        step();
        rst = 1'b0;
        idle();
        #1;
        n_vec++; if (in_ack !== 1'b0) begin n_err++; $display("FAIL rm_ack got %0d want 0", in_ack); end
        n_vec++; if (in_empty !== 1'b0) begin n_err++; $display("FAIL rm_empty got %0d want 0", in_empty); end
        n_vec++; if (in_data !== 12'd0) begin n_err++; $display("FAIL rm_data got %0d want 0", in_data); end
        n_vec++; if (ovf !== 3'b000) begin n_err++; $display("FAIL rm_ovf got %b want 000", ovf); end
        for (int ch = 0; ch < 3; ch++) begin
            in_chan = CW'(ch); dr_chan = CW'(ch);
            #1;
            n_vec++; if (in_size !== 3'd0) begin n_err++; $display("FAIL rm_size[%0d] got %0d want 0", ch, in_size); end
            n_vec++; if (dr_valid !== 1'b0) begin n_err++; $display("FAIL rm_dr_valid[%0d] got %0d want 0", ch, dr_valid); end
        end
        step();
        n_vec++; if (in_ack !== 1'b0) begin n_err++; $display("FAIL rm_ack_late got %0d want 0", in_ack); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        last_pop = '0;
        test_reset();
        test_load_pop();
        test_out_drain();
        test_overflow();
        test_full_pop();
        test_bad_chan();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
